wb_arbiter: RTL and testbench

//  Shares the single writeback bus (wb_valid/wb_error/wb_robid/wb_rd/wb_result) among the

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_arbiter_rr_arbiter.sv | 37 +++
 rtl/wb_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared core defines: writeback widths, requester indices, small helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package wb_arbiter_pkg;

    // Default widths shared with exers and the ALUs.
    localparam int WB_NREQ    = 4;
    localparam int WB_ROBID_W = 7;
    localparam int WB_RD_W    = 6;
    localparam int WB_DATA_W  = 32;

    // Requester indices on the writeback arbiter.
    localparam int REQ_SCALU0 = 0;
    localparam int REQ_SCALU1 = 1;
    localparam int REQ_MCALU0 = 2;
    localparam int REQ_MCALU1 = 3;

    // Index increment with wrap at n, used for the round-robin pointer.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin one-hot picker: highest priority at ptr, then ptr+1, ... with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides what a grant means.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;
    logic         found;

    // Rotate right so that index ptr lands on bit 0.
    assign req_rot = N'({req, req} >> ptr);

    // Fixed priority on the rotated vector: lowest set bit wins.
    always_comb begin
        gnt_rot = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_rot[i] && !found) begin
                gnt_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Rotate the winner back into original index space.
    assign grant = N'(({gnt_rot, gnt_rot} << ptr) >> N);
    assign any   = |req;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback bus arbiter: one holding slot per execute unit, round-robin drain onto a registered bus.
// Latency: req_valid in cycle N with free slot -> wb_valid in N+2; 1 result/cycle sustained.
// Backpressure: req_stall[i] (combinational) while slot i is full and not granted; flush drops, never stalls.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ    = WB_NREQ,
    parameter int ROBID_W = WB_ROBID_W,
    parameter int RD_W    = WB_RD_W,
    parameter int DATA_W  = WB_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_error,
    input  logic [NREQ*ROBID_W-1:0]   req_robid,
    input  logic [NREQ*RD_W-1:0]      req_rd,
    input  logic [NREQ*DATA_W-1:0]    req_result,
    output logic [NREQ-1:0]           req_stall,
    output logic                      wb_valid,
    output logic                      wb_error,
    output logic [ROBID_W-1:0]        wb_robid,
    output logic [RD_W-1:0]           wb_rd,
    output logic [DATA_W-1:0]         wb_result,
    input  logic                      rob_flush
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic               error;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic [DATA_W-1:0]  result;
    } slot_t;

    slot_t             slot_q [NREQ];
    logic [NREQ-1:0]   slot_valid;
    logic [PTR_W-1:0]  rr_ptr;

    logic [NREQ-1:0]   grant;
    logic              any_grant;
    logic [NREQ-1:0]   accept;
    slot_t             grant_slot;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              do_wb;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (slot_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_grant)
    );

    // A slot being drained this cycle can take a new result, so only
    // full-and-waiting slots push back. Flush does not change the stall view.
    assign req_stall = slot_valid & ~grant;
    assign accept    = req_valid & ~req_stall & {NREQ{~rob_flush}};
    assign do_wb     = any_grant & ~rob_flush;

    // Select the granted slot's contents and its index.
    always_comb begin
        grant_slot = '0;
        grant_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_slot = slot_q[i];
                grant_idx  = PTR_W'(i);
            end
        end
        ptr_next = PTR_W'(wrap_inc(32'(grant_idx), NREQ));
    end

    // Slot occupancy: flush empties everything, accept fills, grant empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rob_flush) begin
                    slot_valid[i] <= 1'b0;
                end else if (accept[i]) begin
                    slot_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload: captured only on accept; contents are ignored while the slot is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                slot_q[i].error  <= req_error[i];
                slot_q[i].robid  <= req_robid[i*ROBID_W +: ROBID_W];
                slot_q[i].rd     <= req_rd[i*RD_W +: RD_W];
                slot_q[i].result <= req_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pointer moves past the winner; it is left alone on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_grant && !rob_flush) begin
            rr_ptr <= ptr_next;
        end
    end

    // Registered bus: payload holds its last value when nothing is broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_error  <= 1'b0;
            wb_robid  <= '0;
            wb_rd     <= '0;
            wb_result <= '0;
        end else begin
            wb_valid <= do_wb;
            if (do_wb) begin
                wb_error  <= grant_slot.error;
                wb_robid  <= grant_slot.robid;
                wb_rd     <= grant_slot.rd;
                wb_result <= grant_slot.result;
            end
        end
    end

    // The picker must never grant more than one slot, nor an empty one.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_full:   assert property (@(posedge clk) disable iff (rst) (grant & ~slot_valid) == '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected broadcasts queued at stimulus time, popped by a bus monitor.
// Latency: checks wb at N+2 and stall on the cycle of each event.
// Backpressure: stall values checked directly each interesting cycle.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N   = WB_NREQ;
    localparam int RW  = WB_ROBID_W;
    localparam int RDW = WB_RD_W;
    localparam int DTW = WB_DATA_W;

    typedef struct packed {
        logic           error;
        logic [RW-1:0]  robid;
        logic [RDW-1:0] rd;
        logic [DTW-1:0] result;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_error;
    logic [N*RW-1:0]   req_robid;
    logic [N*RDW-1:0]  req_rd;
    logic [N*DTW-1:0]  req_result;
    logic [N-1:0]      req_stall;
    logic              wb_valid;
    logic              wb_error;
    logic [RW-1:0]     wb_robid;
    logic [RDW-1:0]    wb_rd;
    logic [DTW-1:0]    wb_result;
    logic              rob_flush;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_error  (req_error),
        .req_robid  (req_robid),
        .req_rd     (req_rd),
        .req_result (req_result),
        .req_stall  (req_stall),
        .wb_valid   (wb_valid),
        .wb_error   (wb_error),
        .wb_robid   (wb_robid),
        .wb_rd      (wb_rd),
        .wb_result  (wb_result),
        .rob_flush  (rob_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic e, input logic [RW-1:0] id,
                         input logic [RDW-1:0] d, input logic [DTW-1:0] r);
        req_valid[i]              = v;
        req_error[i]              = e;
        req_robid[i*RW +: RW]     = id;
        req_rd[i*RDW +: RDW]      = d;
        req_result[i*DTW +: DTW]  = r;
    endtask

    task automatic expect_wb(input logic e, input logic [RW-1:0] id,
                             input logic [RDW-1:0] d, input logic [DTW-1:0] r);
        exp_t x;
        x.error  = e;
        x.robid  = id;
        x.rd     = d;
        x.result = r;
        exp_q.push_back(x);
    endtask

    // Bus monitor: every broadcast must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (wb_valid === 1'b1) begin
            got = {wb_error, wb_robid, wb_rd, wb_result};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got robid=%0h result=%0h want no broadcast", wb_robid, wb_result);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL wb_payload: got err=%0b robid=%0h rd=%0h res=%0h want err=%0b robid=%0h rd=%0h res=%0h",
                             got.error, got.robid, got.rd, got.result,
                             want.error, want.robid, want.rd, want.result);
                end
            end
        end
    end

    logic [RDW-1:0] rd_tab  [N];
    logic [DTW-1:0] res_tab [N];

    initial begin
        rd_tab  = '{6'h08, 6'h09, 6'h2A, 6'h0B};
        res_tab = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};

        rst        = 1'b1;
        rob_flush  = 1'b0;
        req_valid  = '0;
        req_error  = '0;
        req_robid  = '0;
        req_rd     = '0;
        req_result = '0;
        tick();
        tick();
        rst = 1'b0;

        // 1. idle after reset
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t1_wb_valid", 64'(wb_valid), 64'd0);
            check("t1_stall", 64'(req_stall), 64'd0);
            check("t1_wb_result", 64'(wb_result), 64'd0);
            tick();
        end

        // 2. single request, wb at N+2 only
        drive(0, 1'b1, 1'b0, 7'h12, 6'h05, 32'hDEADBEEF);
        expect_wb(1'b0, 7'h12, 6'h05, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t2_stall_grant_cycle", 64'(req_stall), 64'd0);
        tick();
        @(negedge clk);
        check("t2_wb_valid_n2", 64'(wb_valid), 64'd1);
        tick();
        @(negedge clk);
        check("t2_wb_valid_n3", 64'(wb_valid), 64'd0);
        tick();

        // 3. all four held valid from reset: rotation 0,1,2,3,...
        rst = 1'b1;
        for (int i = 0; i < N; i++)
            drive(i, 1'b1, (i == 3), RW'(i), rd_tab[i], res_tab[i]);
        for (int k = 0; k < 16; k++)
            expect_wb((k % 4) == 3, RW'(k % 4), rd_tab[k % 4], res_tab[k % 4]);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t3_c0_stall", 64'(req_stall), 64'd0);
        check("t3_c0_wb_valid", 64'(wb_valid), 64'd0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            @(negedge clk);
            check("t3_stall_rotation", 64'(req_stall), 64'(4'hF & ~(4'b0001 << ((c - 1) % 4))));
        end
        tick();
        req_valid = '0;
        repeat (6) tick();

        // 4. slot 2 refilled while granted
        drive(2, 1'b1, 1'b0, 7'h40, 6'h11, 32'h0000_4040);
        expect_wb(1'b0, 7'h40, 6'h11, 32'h0000_4040);
        tick();
        drive(2, 1'b1, 1'b0, 7'h41, 6'h12, 32'h0000_4141);
        drive(0, 1'b1, 1'b0, 7'h50, 6'h13, 32'h0000_5050);
        expect_wb(1'b0, 7'h50, 6'h13, 32'h0000_5050);
        expect_wb(1'b0, 7'h41, 6'h12, 32'h0000_4141);
        @(negedge clk);
        check("t4_refill_stall", 64'(req_stall), 64'd0);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t4_slot2_waiting", 64'(req_stall), 64'h4);
        tick();
        @(negedge clk);
        check("t4_slot2_granted", 64'(req_stall), 64'd0);
        repeat (3) tick();

        // 5. flush with slots 0 and 3 full and unit 1 offering
        drive(0, 1'b1, 1'b0, 7'h30, 6'h01, 32'h0000_3030);
        drive(3, 1'b1, 1'b0, 7'h33, 6'h02, 32'h0000_3333);
        tick();
        req_valid = '0;
        drive(1, 1'b1, 1'b0, 7'h31, 6'h03, 32'h0000_3131);
        rob_flush = 1'b1;
        @(negedge clk);
        check("t5_stall_preflush", 64'(req_stall), 64'h1);
        tick();
        rob_flush = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("t5_wb_valid_after_flush", 64'(wb_valid), 64'd0);
        check("t5_slots_empty", 64'(req_stall), 64'd0);
        drive(0, 1'b1, 1'b0, 7'h60, 6'h04, 32'h0000_6060);
        drive(3, 1'b1, 1'b0, 7'h63, 6'h05, 32'h0000_6363);
        expect_wb(1'b0, 7'h63, 6'h05, 32'h0000_6363);
        expect_wb(1'b0, 7'h60, 6'h04, 32'h0000_6060);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t5_no_dropped_broadcast", 64'(wb_valid), 64'd0);
        repeat (4) tick();

        // 6. reset while three slots full and wb active
        for (int i = 0; i < 3; i++)
            drive(i, 1'b1, 1'b0, RW'(7'h70 + i), RDW'(6'h18 + i), DTW'(32'hC0DE_0000 + i));
        tick();
        expect_wb(1'b0, 7'h71, 6'h19, 32'hC0DE_0001);
        @(negedge clk);
        check("t6_stall_before_rst", 64'(req_stall), 64'h5);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_wb_valid_before_rst", 64'(wb_valid), 64'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            expect_wb(1'b0, RW'(7'h70 + i), RDW'(6'h18 + i), DTW'(32'hC0DE_0000 + i));
        @(negedge clk);
        check("t6_wb_valid_after_rst", 64'(wb_valid), 64'd0);
        check("t6_slots_empty", 64'(req_stall), 64'd0);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t6_first_grant_idx0", 64'(req_stall), 64'h6);
        tick();
        @(negedge clk);
        check("t6_second_grant_idx1", 64'(req_stall), 64'h4);
        tick();
        @(negedge clk);
        check("t6_third_grant_idx2", 64'(req_stall), 64'd0);
        repeat (5) tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
